// File: rtl/onehot_grant_decoder.sv
// Expands a binary request index into a registered one-hot grant held for HOLD cycles.
// Out-of-range indices are rejected with a one-cycle err pulse; in_ready stalls the encoder while busy.

module onehot_grant_decoder #(
    parameter int N     = 4,
    parameter int IDX_W = 2,
    parameter int HOLD  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic             done,
    output logic             err
);

    localparam int                 CNT_W    = $clog2(HOLD + 1);
    localparam logic [IDX_W:0]     N_LIM    = (IDX_W + 1)'(N);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [N-1:0]     grant_r;
    logic [N-1:0]     grant_s;
    logic             grant_valid_r;
    logic             grant_valid_s;
    logic             done_r;
    logic             done_s;
    logic             err_r;
    logic             err_s;
    logic             accept_s;
    logic             in_range_s;
    logic [N-1:0]     onehot_s;

    // Binary index to one-hot; indices >= N decode to all-zero.
    function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] oh;
        for (int i = 0; i < N; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    assign in_ready    = (state_r == ST_IDLE);
    assign accept_s    = in_valid && (state_r == ST_IDLE);
    assign in_range_s  = ({1'b0, in_idx} < N_LIM);
    assign onehot_s    = idx_to_onehot(in_idx);

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign done        = done_r;
    assign err         = err_r;

    // Next-state and next-output decode; done/err default low so they pulse for one cycle.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        grant_s       = grant_r;
        grant_valid_s = grant_valid_r;
        done_s        = 1'b0;
        err_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (in_range_s) begin
                        state_s       = ST_HOLD;
                        cnt_s         = CNT_LOAD;
                        grant_s       = onehot_s;
                        grant_valid_s = 1'b1;
                    end else begin
                        err_s         = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    // Counter exhausted: drop grant and signal completion in the same cycle.
                    state_s       = ST_IDLE;
                    grant_s       = {N{1'b0}};
                    grant_valid_s = 1'b0;
                    done_s        = 1'b1;
                end
            end
            default: begin
                state_s       = ST_IDLE;
                cnt_s         = CNT_ZERO;
                grant_s       = {N{1'b0}};
                grant_valid_s = 1'b0;
            end
        endcase
    end

    // State register and registered outputs; reset truncates any grant with no done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            grant_r       <= {N{1'b0}};
            grant_valid_r <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            grant_r       <= grant_s;
            grant_valid_r <= grant_valid_s;
            done_r        <= done_s;
            err_r         <= err_s;
        end
    end

    onehot_grant_decoder_chk #(
        .N     (N),
        .IDX_W (IDX_W),
        .HOLD  (HOLD)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .in_ready    (in_ready),
        .grant       (grant),
        .grant_valid (grant_valid),
        .done        (done),
        .err         (err)
    );

endmodule

// Output invariants and parameter legality for onehot_grant_decoder.
module onehot_grant_decoder_chk #(
    parameter int N     = 4,
    parameter int IDX_W = 2,
    parameter int HOLD  = 3
) (
    input logic         clk,
    input logic         rst,
    input logic         in_ready,
    input logic [N-1:0] grant,
    input logic         grant_valid,
    input logic         done,
    input logic         err
);

    a_params: assert property (@(posedge clk)
        (N >= 2) && (N <= 16) && (IDX_W == $clog2(N)) && (HOLD >= 1) && (HOLD <= 255));

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));

    a_gvalid: assert property (@(posedge clk) disable iff (rst) grant_valid == (|grant));

    a_done_excl: assert property (@(posedge clk) disable iff (rst) !(done && grant_valid));

    a_err_excl: assert property (@(posedge clk) disable iff (rst) !(err && grant_valid));

    // The block is busy exactly while a grant is being driven.
    a_ready: assert property (@(posedge clk) disable iff (rst) in_ready == !grant_valid);

endmodule
